// File: rtl/dbus_dma_if.sv
// Initiator-side data-bus bundle for dbus_dma: registered address/write data/we,
// request/grant handshake and read data returned one cycle after a granted read.
interface dbus_dma_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic          m_req;
  logic          bus_gnt;
  logic [DW-1:0] m_rdata;

  modport master (output m_addr, m_wdata, m_we, m_req, input bus_gnt, m_rdata);
  modport slave  (input m_addr, m_wdata, m_we, m_req, output bus_gnt, m_rdata);
endinterface

// File: rtl/dbus_dma.sv
// Single-channel word-by-word block copy engine on the 16-bit data bus.
// Define DMA_FILL_EN to build the constant-fill mode (mode_i = 1); otherwise every transfer is a copy.
module dbus_dma #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
  input  logic [15:0]   len_i,
  input  logic          mode_i,
  input  logic [DW-1:0] fill_val_i,
  dbus_dma_if.master    bus,
  output logic          busy_o,
  output logic          done_o,
  output logic [15:0]   remain_o
);

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_CAP, ST_WR, ST_DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [15:0]   remain_q, remain_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          m_we_q, m_we_d;

  logic          accept;
  logic          wr_done;
  logic          last_word;
  logic          fill_mode_d;
  logic [DW-1:0] fill_val_d;

  assign accept    = (state_q == ST_IDLE) && start_i;
  assign wr_done   = (state_q == ST_WR) && bus.bus_gnt;
  assign last_word = (remain_q == 16'd1);

`ifdef DMA_FILL_EN
  logic          fill_mode_q;
  logic [DW-1:0] fill_val_q;

  // Mode and constant are taken live on the accepting edge, held afterwards.
  assign fill_mode_d = accept ? mode_i     : fill_mode_q;
  assign fill_val_d  = accept ? fill_val_i : fill_val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_mode_q <= 1'b0;
      fill_val_q  <= '0;
    end else begin
      fill_mode_q <= fill_mode_d;
      fill_val_q  <= fill_val_d;
    end
  end
`else
  logic unused_fill;
  assign unused_fill = ^{mode_i, fill_val_i};
  assign fill_mode_d = 1'b0;
  assign fill_val_d  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i == 16'd0)   state_d = ST_DONE;
          else if (fill_mode_d) state_d = ST_WR;
          else                  state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (abort_i)          state_d = ST_DONE;
        else if (bus.bus_gnt) state_d = ST_CAP;
      end
      ST_CAP:  state_d = abort_i ? ST_DONE : ST_WR;
      ST_WR: begin
        // A granted write in the abort cycle still completes before DONE.
        if (abort_i || (wr_done && last_word)) state_d = ST_DONE;
        else if (wr_done && !fill_mode_d)      state_d = ST_RD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.m_req = (state_q == ST_RD) || (state_q == ST_WR);
    busy_o    = (state_q == ST_RD) || (state_q == ST_CAP) || (state_q == ST_WR);
    done_o    = (state_q == ST_DONE);
  end

  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    remain_d = remain_q;
    data_d   = data_q;
    if (accept) begin
      src_d    = src_i;
      dst_d    = dst_i;
      remain_d = len_i;
    end
    if (state_q == ST_CAP) data_d = bus.m_rdata;
    if (wr_done) begin
      src_d    = src_q + AW'(1);
      dst_d    = dst_q + AW'(1);
      remain_d = remain_q - 16'd1;
    end
  end

  // Bus outputs are registered, so they are computed from the state being entered.
  always_comb begin
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_we_d    = 1'b0;
    case (state_d)
      ST_RD: m_addr_d = src_d;
      ST_WR: begin
        m_addr_d  = dst_d;
        m_wdata_d = fill_mode_d ? fill_val_d : data_d;
        m_we_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      remain_q  <= '0;
      data_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_we_q    <= 1'b0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      remain_q  <= remain_d;
      data_q    <= data_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_we_q    <= m_we_d;
    end
  end

  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_we    = m_we_q;
  assign remain_o    = remain_q;

endmodule

// File: tb/tb_dbus_dma.sv
// Scoreboard bench for dbus_dma: a word-level reference model queues expected bus
// reads/writes, and a monitor compares them against granted bus cycles.
module tb_dbus_dma;
  localparam int AW = 16;
  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] src = '0, dst = '0, len = '0, fill_val = '0;
  logic        busy, done;
  logic [15:0] remain;

  dbus_dma_if #(.AW(AW), .DW(DW)) bus ();

  dbus_dma #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .src_i(src), .dst_i(dst), .len_i(len), .mode_i(mode), .fill_val_i(fill_val),
    .bus(bus), .busy_o(busy), .done_o(done), .remain_o(remain)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_seen = 0;
  int req_seen = 0;

  logic [15:0] exp_rd[$];
  logic [31:0] exp_wr[$];

  logic [15:0] bus_mem [65536];
  bit          bus_wr  [65536];
  logic [15:0] ref_mem [65536];
  bit          ref_wr  [65536];

  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0, pl_data = '0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bus target: registered read data one cycle after a granted read, junk otherwise.
  always @(posedge clk) begin
    if (pl_en) begin
      bus_mem[pl_addr] <= pl_data;
      bus_wr[pl_addr]  <= 1'b1;
    end else if (rst_n && bus.m_req && bus.m_we && bus.bus_gnt) begin
      bus_mem[bus.m_addr] <= bus.m_wdata;
      bus_wr[bus.m_addr]  <= 1'b1;
    end
    if (rst_n && bus.m_req && !bus.m_we && bus.bus_gnt)
      bus.m_rdata <= bus_wr[bus.m_addr] ? bus_mem[bus.m_addr] : init_val(bus.m_addr);
    else
      bus.m_rdata <= 16'($urandom);
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && bus.m_req) begin
      req_seen++;
      if (bus.bus_gnt && bus.m_we) begin
        wr_seen++;
        if (exp_wr.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: addr %h data %h, no write expected", bus.m_addr, bus.m_wdata);
        end else check("bus_write", {bus.m_addr, bus.m_wdata}, exp_wr.pop_front());
      end else if (bus.bus_gnt) begin
        if (exp_rd.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_read: addr %h, no read expected", bus.m_addr);
        end else check("bus_read", {16'h0, bus.m_addr}, {16'h0, exp_rd.pop_front()});
      end
    end
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    ref_mem[a] = v;
    ref_wr[a]  = 1'b1;
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // gmode: 0 grant high, 1 grant low in cycles st_lo..st_hi, 2 random grant.
  // words: how many words are expected to move (less than n only when aborting).
  task automatic run(input string tag, input logic [15:0] s, input logic [15:0] d,
                     input logic [15:0] n, input logic md, input logic [15:0] fv,
                     input int gmode, input int st_lo, input int st_hi,
                     input int ab_cyc, input int words, input int sp_cyc);
    int cyc, done_cyc, exp_done, wr0, req0, nn;
    bit fill, busy_seen, busy_at_done;
    logic [15:0] v, a_s, a_d, rem_at_done;
`ifdef DMA_FILL_EN
    fill = md;
`else
    fill = 1'b0;
`endif
    nn = int'(n);
    for (int i = 0; i < words; i++) begin
      a_s = s + 16'(i);
      a_d = d + 16'(i);
      v = fill ? fv : (ref_wr[a_s] ? ref_mem[a_s] : init_val(a_s));
      if (!fill) exp_rd.push_back(a_s);
      exp_wr.push_back({a_d, v});
      ref_mem[a_d] = v;
      ref_wr[a_d]  = 1'b1;
    end
    if (nn == 0)          exp_done = 1;
    else if (ab_cyc > 0)  exp_done = ab_cyc + 1;
    else if (gmode == 2)  exp_done = -1;
    else exp_done = (fill ? nn + 1 : 3 * nn + 1) + ((gmode == 1) ? st_hi - st_lo + 1 : 0);

    wr0 = wr_seen; req0 = req_seen;
    src = s; dst = d; len = n; mode = md; fill_val = fv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; done_cyc = -1; busy_seen = 1'b0; busy_at_done = 1'b0; rem_at_done = '0;
    while (cyc <= 600) begin
      case (gmode)
        1:       bus.bus_gnt = !(cyc >= st_lo && cyc <= st_hi);
        2:       bus.bus_gnt = ($urandom_range(3) != 0);
        default: bus.bus_gnt = 1'b1;
      endcase
      abort = (cyc == ab_cyc);
      start = (cyc == sp_cyc);
      if (start) begin src = ~s; dst = ~d; len = 16'd1; end
      @(negedge clk);
      if (done) begin
        done_cyc = cyc; busy_at_done = busy; rem_at_done = remain;
        break;
      end
      busy_seen |= busy;
      @(posedge clk); #1;
      start = 1'b0; src = s; dst = d; len = n;
      cyc++;
    end
    abort = 1'b0; start = 1'b0; bus.bus_gnt = 1'b1;
    @(posedge clk); #1;

    check({tag, "_done_seen"}, 32'(done_cyc > 0), 32'd1);
    if (exp_done > 0) check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({tag, "_remain"}, {16'h0, rem_at_done}, 32'(nn - words));
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    check({tag, "_writes"}, 32'(wr_seen - wr0), 32'(words));
    check({tag, "_busy_during"}, 32'(busy_seen), 32'(nn != 0));
    if (nn == 0) check({tag, "_no_req"}, 32'(req_seen - req0), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] rs, rd, rn, rf;
    logic        rm;
    int          gm;
    bus.bus_gnt = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_m_addr", {16'h0, bus.m_addr}, 32'h0);
    check("rst_m_wdata", {16'h0, bus.m_wdata}, 32'h0);
    check("rst_m_we", 32'(bus.m_we), 32'h0);
    check("rst_m_req", 32'(bus.m_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_remain", {16'h0, remain}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    preload(16'h0010, 16'h00A1);
    preload(16'h0011, 16'h00B2);
    preload(16'h0012, 16'h00C3);
    preload(16'h0013, 16'h00D4);
    run("copy4", 16'h0010, 16'h0040, 16'd4, 1'b0, 16'h0, 0, 0, 0, 0, 4, 0);
    run("zero_len", 16'h0020, 16'h0030, 16'd0, 1'b0, 16'h0, 0, 0, 0, 0, 0, 0);
    run("stall", 16'h0200, 16'h0300, 16'd2, 1'b0, 16'h0, 1, 4, 6, 0, 2, 0);
    run("wrap", 16'h1FFF, 16'hFFFF, 16'd2, 1'b0, 16'h0, 0, 0, 0, 0, 2, 0);
    run("abort", 16'h0400, 16'h0500, 16'd8, 1'b0, 16'h0, 0, 0, 0, 9, 3, 5);
    run("fill", 16'h0600, 16'h0100, 16'd3, 1'b1, 16'h5A5A, 0, 0, 0, 0, 3, 0);

    for (int k = 0; k < 24; k++) begin
      rs = 16'($urandom);
      rd = 16'($urandom);
      rn = 16'($urandom_range(1, 6));
      rm = 1'($urandom_range(0, 1));
      rf = 16'($urandom);
      gm = ($urandom_range(0, 1) == 0) ? 0 : 2;
      run($sformatf("rnd%0d", k), rs, rd, rn, rm, rf, gm, 0, 0, 0, int'(rn), 0);
    end

    check("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    check("exp_rd_drained", 32'(exp_rd.size()), 32'd0);

    // Asynchronous reset in the middle of a write must drop the bus cycle at once.
    exp_rd.push_back(16'h0700);
    src = 16'h0700; dst = 16'h0800; len = 16'd2; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_we", 32'(bus.m_we), 32'd1);
    check("pre_reset_read_done", 32'(exp_rd.size()), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_we", 32'(bus.m_we), 32'd0);
    check("async_rst_req", 32'(bus.m_req), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    exp_rd.delete();
    exp_wr.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
